// File: rtl/uart_out_port_if.sv
// CPU-side bus of the SAP-3 UART output port: OUT strobe and data in, line and FIFO status out.
`timescale 1ns/1ps
interface uart_out_port_if #(
  parameter int DEPTH = 4
);
  localparam int NW = $clog2(DEPTH) + 1;

  logic          load;
  logic [7:0]    data_in;
  logic          tx;
  logic          full;
  logic          empty;
  logic          busy;
  logic          overflow;
  logic [NW-1:0] count;

  modport master (output load, data_in, input tx, full, empty, busy, overflow, count);
  modport slave  (input load, data_in, output tx, full, empty, busy, overflow, count);
endinterface

// File: rtl/uart_out_port.sv
// SAP-3 OUT port: synchronizes the slow OUT strobe, queues bytes in a small FIFO,
// and shifts each one out as 8N1 UART on tx.
`timescale 1ns/1ps
module uart_out_port #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_out_port_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int NW  = AW + 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          s1, s2, s3;
  logic          wr, pop, acc, full, empty;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [NW-1:0] count;
  logic          overflow;

  state_t        state;
  logic [CW-1:0] bcnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          tx_q, busy_q;

  assign wr    = s2 & ~s3;
  assign full  = (count == NW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;
  // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
  assign acc   = wr && (!full || pop);

  always_ff @(posedge clk)
    if (acc) mem[wptr] <= bus.data_in;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s3, s2, s1} <= 3'b000;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, bus.load};
      if (acc)        wptr     <= wptr + AW'(1);
      if (pop)        rptr     <= rptr + AW'(1);
      if (wr && !acc) overflow <= 1'b1;
      count <= count + NW'(acc) - NW'(pop);
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      bcnt   <= '0;
      idx    <= '0;
      shift  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift  <= mem[rptr];
            bcnt   <= '0;
            state  <= START;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START:
          if (bcnt == TC) begin
            bcnt  <= '0;
            idx   <= '0;
            state <= DATA;
            tx_q  <= shift[0];
          end else bcnt <= bcnt + CW'(1);
        DATA:
          if (bcnt == TC) begin
            bcnt  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              idx  <= idx + 3'd1;
              tx_q <= shift[1];
            end
          end else bcnt <= bcnt + CW'(1);
        STOP:
          if (bcnt == TC) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else bcnt <= bcnt + CW'(1);
        default: state <= IDLE;
      endcase
    end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow;
  assign bus.count    = count;
endmodule
